axis_rx_frame_guard: RTL and testbench

Write-side frame source for the packet-mode async FIFO. It converts a non-stallable raw receive byte stream (MAC RX side, `s_aclk` domain) into an AXI-Stream master with `tuser` frame-abort signalling. Frames are terminated with `tlast=1, tuser=1` on:

- upstream error,
- length violation, or
- local overflow.

The FIFO discards such a frame by rewinding to its last committed frame.

---
 rtl/eth_axis_pkg.sv | 14 +
 rtl/reset_sync.sv | 31 +++
 rtl/axis_rx_frame_guard.sv | 169 ++++++++++++++++
 tb/tb_axis_rx_frame_guard.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/eth_axis_pkg.sv
// Shared Ethernet AXI-Stream definitions: frame-guard state encoding and
// default legal frame-length bounds.
package eth_axis_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } frame_guard_state_t;

  localparam int ETH_MIN_LEN = 64;
  localparam int ETH_MAX_LEN = 1518;

endpackage

// File: rtl/reset_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, releases on the
// second rising edge of s_aclk after s_sresetn goes high.
module reset_sync (
  input  logic s_aclk,
  input  logic s_sresetn,
  output logic rst_n_sync
);

  logic meta_q;
  logic sync_q;
  logic meta_d;
  logic sync_d;

  always_comb begin
    meta_d = 1'b1;
    sync_d = meta_q;
  end

  always_ff @(posedge s_aclk or negedge s_sresetn) begin
    if (!s_sresetn) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign rst_n_sync = sync_q;

endmodule

// File: rtl/axis_rx_frame_guard.sv
// Converts a non-stallable raw RX byte stream into an AXI-Stream master that
// terminates bad or overflowed frames with tlast=1, tuser=1.
//
// state | meaning
// IDLE  | between frames; next rx_valid beat is beat 1 of a new frame
// PASS  | forwarding beats of the current frame
// DROP  | discarding the rest of a frame already closed or aborted
module axis_rx_frame_guard
  import eth_axis_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16,
  parameter int MIN_LEN    = ETH_MIN_LEN,
  parameter int MAX_LEN    = ETH_MAX_LEN
) (
  input  logic                  s_aclk,
  input  logic                  s_sresetn,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  input  logic                  rx_last,
  input  logic                  rx_err,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic                  m_axis_trdy,
  output logic                  frame_good,
  output logic                  frame_bad
);

  localparam logic [LEN_WIDTH-1:0] LEN_ONE    = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] LEN_MIN    = LEN_WIDTH'(MIN_LEN);
  localparam logic [LEN_WIDTH-1:0] LEN_MAX    = LEN_WIDTH'(MAX_LEN);
  localparam logic [LEN_WIDTH-1:0] LEN_MAX_P1 = LEN_WIDTH'(MAX_LEN + 1);

  logic rst_n;

  reset_sync u_reset_sync (
    .s_aclk     (s_aclk),
    .s_sresetn  (s_sresetn),
    .rst_n_sync (rst_n)
  );

  frame_guard_state_t state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic                  err_seen_q, err_seen_d;
  logic                  abort_pending_q, abort_pending_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tlast_q, tlast_d;
  logic                  tuser_q, tuser_d;
  logic                  frame_good_q, frame_good_d;
  logic                  frame_bad_q, frame_bad_d;

  logic                  reg_free;
  logic [LEN_WIDTH-1:0]  beat_n;

  always_comb begin
    state_d         = state_q;
    len_d           = len_q;
    err_seen_d      = err_seen_q;
    abort_pending_d = abort_pending_q;
    valid_d         = valid_q;
    tdata_d         = tdata_q;
    tlast_d         = tlast_q;
    tuser_d         = tuser_q;

    reg_free = !valid_q || m_axis_trdy;

    // Saturating beat number including the current beat.
    if (state_q == IDLE) begin
      beat_n = LEN_ONE;
    end else if (&len_q) begin
      beat_n = len_q;
    end else begin
      beat_n = len_q + LEN_ONE;
    end

    if (m_axis_trdy) begin
      valid_d = 1'b0;
    end

    // A pending abort claims the register ahead of any same-cycle input beat.
    if (abort_pending_q && reg_free) begin
      valid_d         = 1'b1;
      tdata_d         = '0;
      tlast_d         = 1'b1;
      tuser_d         = 1'b1;
      abort_pending_d = 1'b0;
    end

    case (state_q)
      IDLE, PASS: begin
        if (rx_valid) begin
          err_seen_d = err_seen_q || rx_err;
          len_d      = beat_n;
          if (!reg_free || abort_pending_q) begin
            abort_pending_d = 1'b1;
            state_d         = rx_last ? IDLE : DROP;
          end else begin
            valid_d = 1'b1;
            tdata_d = rx_data;
            if (rx_last) begin
              tlast_d = 1'b1;
              tuser_d = err_seen_q || rx_err || (beat_n < LEN_MIN) || (beat_n > LEN_MAX);
              state_d = IDLE;
            end else if (beat_n == LEN_MAX_P1) begin
              tlast_d = 1'b1;
              tuser_d = 1'b1;
              state_d = DROP;
            end else begin
              tlast_d = 1'b0;
              tuser_d = 1'b0;
              state_d = PASS;
            end
          end
        end
      end
      DROP: begin
        if (rx_valid && rx_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) begin
      len_d      = '0;
      err_seen_d = 1'b0;
    end

    frame_good_d = valid_q && m_axis_trdy && tlast_q && !tuser_q;
    frame_bad_d  = valid_q && m_axis_trdy && tlast_q && tuser_q;
  end

  always_ff @(posedge s_aclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      len_q           <= '0;
      err_seen_q      <= 1'b0;
      abort_pending_q <= 1'b0;
      valid_q         <= 1'b0;
      tdata_q         <= '0;
      tlast_q         <= 1'b0;
      tuser_q         <= 1'b0;
      frame_good_q    <= 1'b0;
      frame_bad_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      len_q           <= len_d;
      err_seen_q      <= err_seen_d;
      abort_pending_q <= abort_pending_d;
      valid_q         <= valid_d;
      tdata_q         <= tdata_d;
      tlast_q         <= tlast_d;
      tuser_q         <= tuser_d;
      frame_good_q    <= frame_good_d;
      frame_bad_q     <= frame_bad_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = valid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign frame_good    = frame_good_q;
  assign frame_bad     = frame_bad_q;

endmodule

// File: tb/tb_axis_rx_frame_guard.sv
// Directed bench for axis_rx_frame_guard: good, short, long, error, overflow
// and mid-frame reset cases with hand-computed expectations.
module tb_axis_rx_frame_guard;

  logic       s_aclk      = 1'b0;
  logic       s_sresetn   = 1'b0;
  logic [7:0] rx_data     = 8'd0;
  logic       rx_valid    = 1'b0;
  logic       rx_last     = 1'b0;
  logic       rx_err      = 1'b0;
  logic       m_axis_trdy = 1'b1;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tlast;
  logic       m_axis_tuser;
  logic       frame_good;
  logic       frame_bad;

  axis_rx_frame_guard dut (
    .s_aclk        (s_aclk),
    .s_sresetn     (s_sresetn),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_last       (rx_last),
    .rx_err        (rx_err),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_trdy   (m_axis_trdy),
    .frame_good    (frame_good),
    .frame_bad     (frame_bad)
  );

  always #5 s_aclk = ~s_aclk;

  int n_checks = 0;
  int n_pass   = 0;
  int good_cnt = 0;
  int bad_cnt  = 0;
  int stab_err = 0;

  logic [9:0] cap_q[$];
  logic       hold_prev = 1'b0;
  logic [9:0] hold_val  = '0;

  // Capture handshakes and pulses at the falling edge, away from DUT updates.
  always @(negedge s_aclk) begin
    if (!s_sresetn) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev && (!m_axis_tvalid || {m_axis_tdata, m_axis_tlast, m_axis_tuser} != hold_val))
        stab_err++;
      hold_prev = m_axis_tvalid && !m_axis_trdy;
      hold_val  = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
    end
    if (m_axis_tvalid && m_axis_trdy) cap_q.push_back({m_axis_tdata, m_axis_tlast, m_axis_tuser});
    if (frame_good) good_cnt++;
    if (frame_bad)  bad_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic drive_beat(input logic [7:0] d, input logic l, input logic e);
    rx_data  = d;
    rx_valid = 1'b1;
    rx_last  = l;
    rx_err   = e;
    @(posedge s_aclk);
    #1;
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    rx_err   = 1'b0;
  endtask

  task automatic send_frame(input int len, input int err_beat);
    for (int k = 1; k <= len; k++) drive_beat(8'(k), k == len, k == err_beat);
  endtask

  task automatic settle();
    repeat (3) @(posedge s_aclk);
    #1;
  endtask

  task automatic check_frame(input string tag, input int exp_len, input logic exp_user,
                             input logic [7:0] exp_last_data);
    int tl;
    int bad_data;
    int n;
    tl       = 0;
    bad_data = 0;
    n        = cap_q.size();
    check({tag, "_beats"}, n, exp_len);
    for (int i = 0; i < n; i++) begin
      if (cap_q[i][1]) tl++;
      if (i < n - 1 && cap_q[i][9:2] != 8'(i + 1)) bad_data++;
    end
    check({tag, "_tlast_count"}, tl, 1);
    check({tag, "_data"}, bad_data, 0);
    if (n > 0) begin
      check({tag, "_last_tlast"}, 32'(cap_q[n-1][1]), 1);
      check({tag, "_last_tuser"}, 32'(cap_q[n-1][0]), 32'(exp_user));
      check({tag, "_last_data"}, 32'(cap_q[n-1][9:2]), 32'(exp_last_data));
    end
  endtask

  int g0, b0;

  initial begin
    repeat (2) @(posedge s_aclk);
    #1;
    check("rst_tvalid", 32'(m_axis_tvalid), 0);
    check("rst_tlast",  32'(m_axis_tlast), 0);
    check("rst_tuser",  32'(m_axis_tuser), 0);
    check("rst_tdata",  32'(m_axis_tdata), 0);
    check("rst_good",   32'(frame_good), 0);
    check("rst_bad",    32'(frame_bad), 0);
    s_sresetn = 1'b1;
    settle();

    // Good 64-beat frame with one-cycle latency on beat 1.
    cap_q.delete(); g0 = good_cnt; b0 = bad_cnt;
    check("pre_tvalid", 32'(m_axis_tvalid), 0);
    drive_beat(8'd1, 1'b0, 1'b0);
    check("lat_tvalid", 32'(m_axis_tvalid), 1);
    check("lat_tdata",  32'(m_axis_tdata), 1);
    for (int k = 2; k <= 64; k++) drive_beat(8'(k), k == 64, 1'b0);
    settle();
    check_frame("good", 64, 1'b0, 8'd64);
    check("good_pulse", good_cnt - g0, 1);
    check("good_nobad", bad_cnt - b0, 0);

    // Short frame.
    cap_q.delete(); g0 = good_cnt; b0 = bad_cnt;
    send_frame(10, 0);
    settle();
    check_frame("short", 10, 1'b1, 8'd10);
    check("short_bad", bad_cnt - b0, 1);
    check("short_nogood", good_cnt - g0, 0);

    // Long frame: closed bad at beat 1519, rest dropped.
    cap_q.delete(); g0 = good_cnt; b0 = bad_cnt;
    send_frame(1600, 0);
    settle();
    check_frame("long", 1519, 1'b1, 8'(1519));
    check("long_bad", bad_cnt - b0, 1);
    cap_q.delete(); g0 = good_cnt;
    send_frame(64, 0);
    settle();
    check_frame("after_long", 64, 1'b0, 8'd64);
    check("after_long_good", good_cnt - g0, 1);

    // Upstream error on beat 5 of 100.
    cap_q.delete(); b0 = bad_cnt;
    send_frame(100, 5);
    settle();
    check_frame("err", 100, 1'b1, 8'd100);
    check("err_bad", bad_cnt - b0, 1);

    // Overflow: trdy low for 2 cycles while beats 21 and 22 arrive.
    cap_q.delete(); g0 = good_cnt; b0 = bad_cnt;
    for (int k = 1; k <= 64; k++) begin
      if (k == 21) m_axis_trdy = 1'b0;
      if (k == 23) begin
        check("ovf_hold_valid", 32'(m_axis_tvalid), 1);
        check("ovf_hold_data",  32'(m_axis_tdata), 20);
        m_axis_trdy = 1'b1;
      end
      drive_beat(8'(k), k == 64, 1'b0);
    end
    settle();
    check_frame("ovf", 21, 1'b1, 8'd0);
    check("ovf_bad", bad_cnt - b0, 1);
    check("ovf_nogood", good_cnt - g0, 0);
    cap_q.delete(); g0 = good_cnt;
    send_frame(64, 0);
    settle();
    check_frame("after_ovf", 64, 1'b0, 8'd64);
    check("after_ovf_good", good_cnt - g0, 1);

    // Reset asserted during beat 30.
    for (int k = 1; k <= 29; k++) drive_beat(8'(k), 1'b0, 1'b0);
    check("pre_rst_tvalid", 32'(m_axis_tvalid), 1);
    rx_data  = 8'd30;
    rx_valid = 1'b1;
    #2;
    s_sresetn = 1'b0;
    #1;
    check("mid_rst_tvalid", 32'(m_axis_tvalid), 0);
    check("mid_rst_tdata",  32'(m_axis_tdata), 0);
    check("mid_rst_tlast",  32'(m_axis_tlast), 0);
    rx_valid = 1'b0;
    repeat (2) @(posedge s_aclk);
    #1;
    s_sresetn = 1'b1;
    settle();
    cap_q.delete(); g0 = good_cnt; b0 = bad_cnt;
    send_frame(64, 0);
    settle();
    check_frame("after_rst", 64, 1'b0, 8'd64);
    check("after_rst_good", good_cnt - g0, 1);
    check("after_rst_nobad", bad_cnt - b0, 0);

    check("stable", stab_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
